// File: rtl/dec_timer_pkg.sv
// Shared constants for the BCD countdown timer: FSM encoding and digit limits.
package dec_timer_pkg;
    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_e;

    localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_ZERO = 4'd0;
endpackage

// File: rtl/m_bcd_digit_down.sv
// One combinational BCD digit: either clamps a load value to 9 or decrements with borrow.
module m_bcd_digit_down
    import dec_timer_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               borrow_in,
    input  logic               clamp_en,
    output logic [DIGIT_W-1:0] next_digit,
    output logic               borrow_out,
    output logic               clamp_flag
);
    always_comb begin
        next_digit = digit;
        borrow_out = 1'b0;
        clamp_flag = 1'b0;
        if (clamp_en) begin
            if (digit > BCD_MAX) begin
                next_digit = BCD_MAX;
                clamp_flag = 1'b1;
            end
        end else if (borrow_in) begin
            if (digit == BCD_ZERO) begin
                next_digit = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                next_digit = digit - 4'd1;
            end
        end
    end
endmodule

// File: rtl/m_dec_down_timer.sv
// Loadable N-digit BCD countdown timer with done pulse, sticky expired state and load clamp.
module m_dec_down_timer
    import dec_timer_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  tick,
    output logic [4*DIGITS-1:0]   q,
    output logic                  running,
    output logic                  done,
    output logic                  expired,
    output logic                  load_err
);
    localparam int W = DIGIT_W * DIGITS;

    state_e         state_q, state_d;
    logic [W-1:0]   q_q, q_d;
    logic           done_q, done_d;
    logic           load_err_q, load_err_d;

    logic [W-1:0]   dig_in, dig_nxt;
    logic [DIGITS:0] borrow;
    logic [DIGITS-1:0] clamp;

    // The digit chain serves both the load clamp and the decrement.
    assign dig_in    = load ? load_val : q_q;
    assign borrow[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        m_bcd_digit_down u_dig (
            .digit      (dig_in[DIGIT_W*g +: DIGIT_W]),
            .borrow_in  (borrow[g]),
            .clamp_en   (load),
            .next_digit (dig_nxt[DIGIT_W*g +: DIGIT_W]),
            .borrow_out (borrow[g+1]),
            .clamp_flag (clamp[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            q_q        <= '0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    // A borrow out of the top digit means q was zero; never wrap below zero.
    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            q_d        = dig_nxt;
            load_err_d = |clamp;
            state_d    = IDLE;
        end else if (stop) begin
            if (state_q == RUN) state_d = IDLE;
        end else if (start && state_q == IDLE && q_q != '0) begin
            state_d = RUN;
        end else if (tick && state_q == RUN && !borrow[DIGITS]) begin
            q_d = dig_nxt;
            if (dig_nxt == '0) begin
                done_d  = 1'b1;
                state_d = EXPIRED;
            end
        end
    end

    always_comb begin
        q        = q_q;
        running  = (state_q == RUN);
        expired  = (state_q == EXPIRED);
        done     = done_q;
        load_err = load_err_q;
    end
endmodule

// File: doc/m_dec_down_timer.md
Name: m_dec_down_timer

Overview:
Loadable N-digit BCD countdown timer. It is the down-counting counterpart of the team's decimal up-counter. Software or an upstream FSM loads a BCD value, starts the timer, and the timer decrements once per external tick enable. When the count reaches 00 it raises a one-cycle done pulse and a sticky expired flag. It sits between a prescaler, which produces tick, and display or sequencing logic, which consumes q, done and expired.

Parameters:
DIGITS, 2, number of BCD digits; q width = 4*DIGITS; max count = 10^DIGITS - 1

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  asynchronous, active-low reset
load  input  1  load load_val into counter (highest priority after reset)
load_val  input  4*DIGITS  BCD preset, digit 0 in bits [3:0]
start  input  1  begin or resume countdown
stop  input  1  pause countdown, count retained
tick  input  1  count-enable strobe, one decrement per cycle high while running
q  output  4*DIGITS  current BCD count
running  output  1  high while state == RUN
done  output  1  one-cycle pulse, high in the cycle q first reads all-zero after a decrement
expired  output  1  high while state == EXPIRED
load_err  output  1  one-cycle pulse: a load contained a digit > 9

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-low.
- Reset values: q=0, state=IDLE, running=0, done=0, expired=0, load_err=0. Reset mid-count discards the count immediately, without waiting for a clock edge.
- States and meaning:
  - IDLE: stopped or paused.
  - RUN: counting.
  - EXPIRED: reached zero.
- Priority each cycle: load > stop > start > tick.
- load, from any state:
  - q <= load_val, with each digit > 9 clamped to 9.
  - load_err=1 next cycle if any digit was clamped.
  - State -> IDLE.
  - start, stop and tick in the same cycle are ignored.
- start in IDLE:
  - If q != 0: -> RUN; running=1 from the next cycle.
  - If q == 0: ignored; stays IDLE; no done.
- start in RUN or EXPIRED: ignored.
- stop in RUN: -> IDLE, q frozen. stop together with tick: no decrement.
- stop in IDLE or EXPIRED: no effect.
- tick in RUN: BCD decrement, registered.
  - Digit 0 decrements by 1. A digit at 0 becomes 9 and borrows from the next digit up; the borrow ripples combinationally through the digits in the same cycle.
  - Example: 10 -> 09; 100 -> 099 for DIGITS=3.
  - Underflow below 0 cannot occur, because RUN is left at zero.
  - If the decremented value == 0: done=1 for exactly one cycle, aligned with q=0; state -> EXPIRED; expired=1 from the same cycle.
- tick in IDLE or EXPIRED: ignored, q unchanged.
- Back-to-back ticks every cycle decrement every cycle; latency from tick to q update is 1 cycle.
- EXPIRED: q holds 0. Leave only via load (-> IDLE) or reset.
- done and load_err are registered pulses, never high for more than one cycle per event.
- q digits never hold values > 9 under any input sequence.

Decomposition:
- Package dec_timer_pkg:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, EXPIRED=2'd2.
  - BCD_MAX=4'd9 and BCD_ZERO=4'd0.
  - Digit width constant 4.
- Sub-module m_bcd_digit_down: one combinational digit.
  - Inputs: digit[3:0], borrow_in, clamp_en.
  - Outputs: next_digit[3:0], borrow_out, clamp_flag.
  - Instantiated DIGITS times in a generate chain.
  - Shared by the decrement path and the load clamp.
- Top level holds the FSM, the q register and the pulse registers.

Test Plan:
- Reset/load: rst low mid-RUN at q=37 -> q=00, running=0, done=0 immediately. Release, load 8'h25 -> q=25, IDLE, load_err=0.
- Full countdown: load 12, start, tick every cycle -> q sequence 11,10,09,...,01,00; done high only on the 00 cycle; expired=1; running=0.
- Borrow ripple: DIGITS=3, load 100, start, one tick -> q=099. Load 000, start -> stays IDLE, no done.
- Pause/resume: load 50, start, 3 ticks -> 47. stop with tick same cycle -> q stays 47, IDLE. Extra ticks ignored. start, tick -> 46.
- Clamp: load 8'hA7 -> q=97, load_err pulse of 1 cycle. Load 8'hFF -> q=99, load_err pulse.
- Priority: in EXPIRED, start+tick -> no change. load 03 with start same cycle -> q=03, IDLE (not RUN), expired=0.
